// File: rtl/decode_issue_ctrl.sv
// Decode/issue control: register scoreboard for RAW/WAW interlocks plus a
// branch FSM that stalls until resolution and kills wrong-path instructions.
module decode_issue_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   d_in_valid,
  input  logic [4:0]             d_in_rs1_key,
  input  logic [4:0]             d_in_rs2_key,
  input  logic [4:0]             d_in_rd_key,
  input  logic                   d_in_uses_rs2,
  input  logic                   d_in_rd_we,
  input  logic                   d_in_is_branch,
  input  logic                   d_in_is_jmp,
  input  logic                   ex_in_resolve,
  input  logic                   ex_in_taken,
  input  logic                   wb_in_rd_we,
  input  logic [4:0]             wb_in_rd_key,
  output logic                   d_out_issue,
  output logic                   d_out_stall,
  output logic                   d_out_kill_instr,
  output logic [31:0]            sb_out_pending,
  output logic [1:0]             ctl_out_state,
  output logic [STALL_CNT_W-1:0] perf_out_stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic [31:0]            pending_q, pending_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   hazard;

  // Only the registered scoreboard is consulted; a same-cycle writeback does not bypass.
  assign hazard = pending_q[d_in_rs1_key]
                | (d_in_uses_rs2 & pending_q[d_in_rs2_key])
                | (d_in_rd_we & pending_q[d_in_rd_key]);

  // Outputs are forced quiet while reset is held low.
  always_comb begin
    d_out_issue      = 1'b0;
    d_out_stall      = 1'b0;
    d_out_kill_instr = 1'b0;
    if (reset) begin
      case (state_q)
        RUN: begin
          d_out_issue = d_in_valid & ~hazard;
          d_out_stall = d_in_valid & hazard;
        end
        BR_WAIT: d_out_stall      = d_in_valid;
        FLUSH:   d_out_kill_instr = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (wb_in_rd_we) begin
      pending_d[wb_in_rd_key] = 1'b0;
    end
    // Set is applied after clear so a same-cycle collision leaves the bit set.
    if (d_out_issue && d_in_rd_we) begin
      pending_d[d_in_rd_key] = 1'b1;
    end
    pending_d[0] = 1'b0;

    stall_cnt_d = stall_cnt_q;
    if (d_out_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (d_out_issue && (d_in_is_branch || d_in_is_jmp)) begin
          state_d = BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (ex_in_resolve) begin
          if (ex_in_taken) begin
            state_d     = FLUSH;
            flush_cnt_d = 3'(FLUSH_CYCLES);
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= 3'd1) begin
          state_d     = RUN;
          flush_cnt_d = 3'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      pending_q   <= 32'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_out_pending     = pending_q;
  assign ctl_out_state      = state_q;
  assign perf_out_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: a reference model queues expected outputs when
// stimulus is driven; they are popped and compared mid-cycle.
module tb_decode_issue_ctrl;

  localparam int FC = 2;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          dValid, usesRs2, rdWe, isBr, isJmp, resolve, taken, wbWe;
  logic [4:0]    rs1, rs2, rd, wbKey;
  logic          issue, stall, kill;
  logic [31:0]   pending;
  logic [1:0]    state;
  logic [SW-1:0] stallCnt;

  typedef struct {
    logic          issue;
    logic          stall;
    logic          kill;
    logic [31:0]   pending;
    logic [1:0]    state;
    logic [SW-1:0] stallCnt;
  } expect_t;

  expect_t expQ[$];

  int checks = 0;
  int errors = 0;

  int            mState;
  int            mCnt;
  logic [31:0]   mPend;
  logic [SW-1:0] mStallCnt;

  always #5 clk = ~clk;

  decode_issue_ctrl #(.FLUSH_CYCLES(FC), .STALL_CNT_W(SW)) dut (
    .clk                (clk),
    .reset              (reset),
    .d_in_valid         (dValid),
    .d_in_rs1_key       (rs1),
    .d_in_rs2_key       (rs2),
    .d_in_rd_key        (rd),
    .d_in_uses_rs2      (usesRs2),
    .d_in_rd_we         (rdWe),
    .d_in_is_branch     (isBr),
    .d_in_is_jmp        (isJmp),
    .ex_in_resolve      (resolve),
    .ex_in_taken        (taken),
    .wb_in_rd_we        (wbWe),
    .wb_in_rd_key       (wbKey),
    .d_out_issue        (issue),
    .d_out_stall        (stall),
    .d_out_kill_instr   (kill),
    .sb_out_pending     (pending),
    .ctl_out_state      (state),
    .perf_out_stall_cnt (stallCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: outputs for the current inputs, then the state advance at the edge.
  task automatic modelStep(output expect_t e);
    logic haz;
    e.issue    = 1'b0;
    e.stall    = 1'b0;
    e.kill     = 1'b0;
    e.pending  = mPend;
    e.state    = 2'(mState);
    e.stallCnt = mStallCnt;
    haz = (rs1 != 0 && mPend[rs1]) || (usesRs2 && rs2 != 0 && mPend[rs2])
       || (rdWe && rd != 0 && mPend[rd]);
    if (reset) begin
      if (mState == 0) begin
        e.issue = dValid && !haz;
        e.stall = dValid && haz;
      end else if (mState == 1) begin
        e.stall = dValid;
      end else begin
        e.kill = 1'b1;
      end
    end
    if (!reset) begin
      mState = 0; mCnt = 0; mPend = 0; mStallCnt = 0;
    end else begin
      if (wbWe && wbKey != 0) mPend[wbKey] = 1'b0;
      if (e.issue && rdWe && rd != 0) mPend[rd] = 1'b1;
      if (e.stall && mStallCnt != {SW{1'b1}}) mStallCnt = mStallCnt + 1'b1;
      if (mState == 0) begin
        if (e.issue && (isBr || isJmp)) mState = 1;
      end else if (mState == 1) begin
        if (resolve) begin
          if (taken) begin mState = 2; mCnt = FC; end
          else mState = 0;
        end
      end else begin
        if (mCnt <= 1) begin mState = 0; mCnt = 0; end
        else mCnt = mCnt - 1;
      end
    end
  endtask

  task automatic applyStimulus(
    input logic       rstN = 1'b1,
    input logic       v = 1'b0,
    input logic [4:0] s1 = 5'd0,
    input logic [4:0] s2 = 5'd0,
    input logic [4:0] d = 5'd0,
    input logic       u2 = 1'b0,
    input logic       we = 1'b0,
    input logic       br = 1'b0,
    input logic       jmp = 1'b0,
    input logic       res = 1'b0,
    input logic       tk = 1'b0,
    input logic       wwe = 1'b0,
    input logic [4:0] wk = 5'd0
  );
    expect_t e, got;
    @(negedge clk);
    reset = rstN; dValid = v; rs1 = s1; rs2 = s2; rd = d; usesRs2 = u2; rdWe = we;
    isBr = br; isJmp = jmp; resolve = res; taken = tk; wbWe = wwe; wbKey = wk;
    modelStep(e);
    expQ.push_back(e);
    #2;
    got = expQ.pop_front();
    checkOutput("issue",    32'(issue),    32'(got.issue));
    checkOutput("stall",    32'(stall),    32'(got.stall));
    checkOutput("kill",     32'(kill),     32'(got.kill));
    checkOutput("pending",  pending,       got.pending);
    checkOutput("state",    32'(state),    32'(got.state));
    checkOutput("stallCnt", 32'(stallCnt), 32'(got.stallCnt));
  endtask

  initial begin
    int stallSeen;
    reset = 1'b0; dValid = 0; rs1 = 0; rs2 = 0; rd = 0; usesRs2 = 0; rdWe = 0;
    isBr = 0; isJmp = 0; resolve = 0; taken = 0; wbWe = 0; wbKey = 0;
    mState = 0; mCnt = 0; mPend = 0; mStallCnt = 0;

    // Reset, including a valid instruction that must not issue.
    applyStimulus(.rstN(1'b0));
    applyStimulus(.rstN(1'b0), .v(1'b1), .d(5'd3), .we(1'b1));

    // RAW on x5: issue writer, dependent stalls until writeback retires.
    applyStimulus(.v(1'b1), .d(5'd5), .we(1'b1));
    stallSeen = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(.v(1'b1), .s1(5'd5), .d(5'd6), .we(1'b1));
      stallSeen += stall;
    end
    applyStimulus(.v(1'b1), .s1(5'd5), .d(5'd6), .we(1'b1), .wwe(1'b1), .wk(5'd5));
    stallSeen += stall;
    applyStimulus(.v(1'b1), .s1(5'd5), .d(5'd6), .we(1'b1));
    checkOutput("rawIssue", 32'(issue), 32'd1);
    checkOutput("rawStallCnt", 32'(stallCnt), 32'(stallSeen));
    applyStimulus(.wwe(1'b1), .wk(5'd6));

    // x0 never becomes pending.
    applyStimulus(.v(1'b1), .d(5'd0), .we(1'b1));
    applyStimulus(.v(1'b1), .s1(5'd0));
    checkOutput("x0NoStall", 32'(stall), 32'd0);
    checkOutput("x0Pending", pending, 32'd0);

    // Set/clear collision on x7: set wins.
    applyStimulus(.v(1'b1), .d(5'd7), .we(1'b1), .wwe(1'b1), .wk(5'd7));
    applyStimulus();
    checkOutput("collision7", 32'(pending[7]), 32'd1);
    applyStimulus(.wwe(1'b1), .wk(5'd7));

    // Taken branch: stall in BR_WAIT, stray resolve elsewhere ignored, FC kills.
    applyStimulus(.res(1'b1), .tk(1'b1));
    applyStimulus(.v(1'b1), .s1(5'd1), .s2(5'd2), .u2(1'b1), .br(1'b1));
    applyStimulus(.v(1'b1), .d(5'd9), .we(1'b1));
    applyStimulus(.v(1'b1), .d(5'd9), .we(1'b1), .res(1'b1), .tk(1'b1));
    for (int i = 0; i < FC; i++) begin
      applyStimulus(.v(1'b1), .d(5'd9), .we(1'b1), .res(1'b1), .tk(1'b1));
      checkOutput("flushKill", 32'(kill), 32'd1);
    end
    applyStimulus(.v(1'b1), .d(5'd10), .we(1'b1));
    checkOutput("postFlushIssue", 32'(issue), 32'd1);
    applyStimulus(.wwe(1'b1), .wk(5'd10));

    // Not-taken jump: back to RUN with no kill cycle.
    applyStimulus(.v(1'b1), .jmp(1'b1));
    applyStimulus(.v(1'b1), .res(1'b1), .tk(1'b0));
    applyStimulus(.v(1'b1), .d(5'd4), .we(1'b1));
    checkOutput("notTakenIssue", 32'(issue), 32'd1);

    // Reset in the middle of a flush with pending bits set.
    applyStimulus(.v(1'b1), .d(5'd11), .we(1'b1), .br(1'b1));
    applyStimulus(.res(1'b1), .tk(1'b1));
    applyStimulus();
    applyStimulus(.rstN(1'b0), .v(1'b1));
    applyStimulus();
    checkOutput("rstPending", pending, 32'd0);
    checkOutput("rstState", 32'(state), 32'd0);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(
        .rstN($urandom_range(0, 49) != 0),
        .v(1'($urandom_range(0, 3) != 0)),
        .s1(5'($urandom_range(0, 7))), .s2(5'($urandom_range(0, 7))),
        .d(5'($urandom_range(0, 7))), .u2(1'($urandom)), .we(1'($urandom)),
        .br(1'($urandom_range(0, 7) == 0)), .jmp(1'($urandom_range(0, 11) == 0)),
        .res(1'($urandom_range(0, 3) == 0)), .tk(1'($urandom)),
        .wwe(1'($urandom_range(0, 1))), .wk(5'($urandom_range(0, 7))));
    end

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
